// File: rtl/muldiv_alu_control.sv
// muldiv_alu_control
//   Extended ALU control for one lane of the dual-issue core. It decodes the
//   6-bit funct field into a 4-bit ALU op. It runs MULT/MULTU/DIV/DIVU as a
//   background iterative engine that owns the HI/LO registers. It raises a
//   stall whenever a HI/LO access (MD, MT or MF) meets a busy engine.
//
// Parameters
//   WIDTH      operand / HI / LO width (even, >= 4)
//   HILO_INIT  reset value of HI and LO
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   aluop       in   [1:0]  main-control ALU class (0 add, 1 sub, 2 funct, 3 add)
//   funct       in   [5:0]  instruction funct field
//   valid       in   instruction in EX is real
//   flush       in   synchronous abort of an in-flight mul/div
//   a, b        in   [WIDTH-1:0] rs / rt operands
//   aluctl      out  [3:0]  ALU op (combinational)
//   stall       out  hold EX and earlier stages (combinational)
//   busy        out  engine running (decoded from the state register)
//   done        out  one-cycle pulse after HI/LO were written by mul/div
//   hilo_rdata  out  [WIDTH-1:0] MFHI/MFLO read data
module muldiv_alu_control #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] HILO_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic             valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       aluctl,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hilo_rdata
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] count;

  logic [WIDTH-1:0] hi, lo;

  // Engine datapath. acc_hi/acc_lo form the running product during a
  // multiply, and the partial remainder / quotient during a divide.
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_hold;
  logic             op_div, div_zero, neg_x, neg_a;

  logic is_r, md, mt, mf, md_accept, mt_accept;
  logic sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  // ALU op decode
  always_comb begin
    aluctl = 4'd2;
    case (aluop)
      2'd1: aluctl = 4'd6;
      2'd2: begin
        case (funct)
          6'h20, 6'h21: aluctl = 4'd2;
          6'h22, 6'h23: aluctl = 4'd6;
          6'h24:        aluctl = 4'd0;
          6'h25:        aluctl = 4'd1;
          6'h26:        aluctl = 4'd13;
          6'h27:        aluctl = 4'd12;
          6'h2A:        aluctl = 4'd7;
          6'h2B:        aluctl = 4'd8;
          6'h00:        aluctl = 4'd3;
          6'h02:        aluctl = 4'd4;
          6'h03:        aluctl = 4'd5;
          default:      aluctl = 4'd0;
        endcase
      end
      default: aluctl = 4'd2;
    endcase
  end

  // HI/LO instruction classes. MD is funct 18..1B: bit1 selects divide,
  // bit0 selects unsigned.
  assign is_r      = valid && (aluop == 2'd2);
  assign md        = is_r && (funct[5:2] == 4'b0110);
  assign mt        = is_r && ((funct == 6'h11) || (funct == 6'h13));
  assign mf        = is_r && ((funct == 6'h10) || (funct == 6'h12));
  assign busy      = (state != S_IDLE);
  assign stall     = busy && (md || mt || mf);
  assign md_accept = md && !busy && !flush;
  assign mt_accept = mt && !busy;

  assign hilo_rdata = funct[1] ? lo : hi;

  // The engine works on magnitudes. The negation of the most negative value
  // wraps to itself, which is still the correct unsigned magnitude.
  assign sa    = !funct[0] && a[WIDTH-1];
  assign sb    = !funct[0] && b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // A multiply step adds the multiplicand when the current multiplier LSB is
  // set, then shifts {sum, acc_lo} right by one.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // Restoring divide step. The shifted remainder is WIDTH+1 bits wide. When
  // it is at least the divisor, the difference is below the divisor, so the
  // low WIDTH bits of the subtraction are exact.
  assign div_ge  = {acc_hi, acc_lo[WIDTH-1]} >= {1'b0, opnd};
  assign div_sub = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]} - opnd;

  assign prod_fix = neg_x ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

  // Sign fix-up applied in the FIX state
  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        res_lo = '1;
        res_hi = a_hold;
      end else begin
        res_lo = neg_x ? -acc_lo : acc_lo;
        res_hi = neg_a ? -acc_hi : acc_hi;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (md_accept) state_next = funct[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:  if (count == CW'(1)) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == S_FIX) && !flush;
      if (flush)
        count <= '0;
      else if (md_accept)
        count <= CW'(WIDTH);
      else if ((state == S_MUL) || (state == S_DIV))
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= HILO_INIT;
      lo <= HILO_INIT;
    end else if ((state == S_FIX) && !flush) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_accept) begin
      if (funct[1])
        lo <= a;
      else
        hi <= a;
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (md_accept) begin
      op_div   <= funct[1];
      div_zero <= funct[1] && (b == '0);
      neg_x    <= sa ^ sb;
      neg_a    <= sa;
      a_hold   <= a;
      acc_hi   <= '0;
      acc_lo   <= funct[1] ? mag_a : mag_b;
      opnd     <= funct[1] ? mag_b : mag_a;
    end else if (state == S_MUL) begin
      acc_hi <= mul_sum[WIDTH:1];
      acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      acc_hi <= div_ge ? div_sub : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
    end
  end

endmodule

// File: tb/tb_muldiv_alu_control.sv
// tb_muldiv_alu_control
//   Directed bench for muldiv_alu_control (WIDTH=32). The stimulus pushes the
//   expected HI/LO read value into a scoreboard queue whenever it issues an
//   MFHI/MFLO. A monitor pops and compares each time the DUT presents an
//   unstalled MF read. Timing, decode, flush and reset are checked inline.
module tb_muldiv_alu_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic        valid;
  logic        flush;
  logic [31:0] a, b;
  logic [3:0]  aluctl;
  logic        stall, busy, done;
  logic [31:0] hilo_rdata;

  muldiv_alu_control #(.WIDTH(32), .HILO_INIT(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct), .valid(valid),
    .flush(flush), .a(a), .b(b), .aluctl(aluctl), .stall(stall), .busy(busy),
    .done(done), .hilo_rdata(hilo_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int done_seen = 0;
  int done_expected = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] ex;
  } alu_vec_t;
  alu_vec_t alu_tab[16] = '{
    '{2'd2, 6'h2B, 4'd8},  '{2'd1, 6'h2B, 4'd6},  '{2'd2, 6'h18, 4'd0},
    '{2'd0, 6'h2A, 4'd2},  '{2'd3, 6'h25, 4'd2},  '{2'd2, 6'h21, 4'd2},
    '{2'd2, 6'h23, 4'd6},  '{2'd2, 6'h24, 4'd0},  '{2'd2, 6'h25, 4'd1},
    '{2'd2, 6'h26, 4'd13}, '{2'd2, 6'h27, 4'd12}, '{2'd2, 6'h2A, 4'd7},
    '{2'd2, 6'h00, 4'd3},  '{2'd2, 6'h02, 4'd4},  '{2'd2, 6'h03, 4'd5},
    '{2'd2, 6'h10, 4'd0}
  };

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn,
                               input logic [31:0] av, input logic [31:0] bv,
                               input logic vl);
    aluop = op;
    funct = fn;
    a     = av;
    b     = bv;
    valid = vl;
  endtask

  task automatic idle();
    applyStimulus(2'd0, 6'h00, 32'h0, 32'h0, 1'b0);
  endtask

  // Called just after a rising edge; the op is accepted at the next edge.
  task automatic issueMd(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
    applyStimulus(2'd2, fn, av, bv, 1'b1);
    @(posedge clk);
    #1 idle();
  endtask

  // Returns at the falling edge of the done cycle, or after a cycle budget.
  task automatic waitDone(output int busy_cycles, output logic ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic readHilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    sb_q.push_back('{{name, "_lo"}, el});
    applyStimulus(2'd2, 6'h12, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    sb_q.push_back('{{name, "_hi"}, eh});
    applyStimulus(2'd2, 6'h10, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    #1 idle();
  endtask

  task automatic runMd(input string name, input logic [5:0] fn, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
    int   cyc;
    logic ok;
    issueMd(fn, av, bv);
    waitDone(cyc, ok);
    checkOutput({name, "_done"}, {31'h0, ok}, 32'h1);
    done_expected++;
    @(posedge clk);
    #1 readHilo(name, eh, el);
  endtask

  // Scoreboard monitor: an MF read is presented when it sits unstalled in EX.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid && aluop == 2'd2 &&
        (funct == 6'h10 || funct == 6'h12) && !stall) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_read: got %h expected none", hilo_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput(mon_e.name, hilo_rdata, mon_e.val);
      end
    end
    if (rst_n === 1'b1 && done === 1'b1) done_seen++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    int   stall_cycles;
    logic ok;

    rst_n = 1'b0;
    flush = 1'b0;
    idle();
    #12;
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_done", {31'h0, done}, 32'h0);
    funct = 6'h12;
    #1 checkOutput("reset_lo", hilo_rdata, 32'h0);
    funct = 6'h10;
    #1 checkOutput("reset_hi", hilo_rdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (alu_tab[i]) begin
      applyStimulus(alu_tab[i].op, alu_tab[i].fn, 32'h0, 32'h0, 1'b0);
      #1 checkOutput($sformatf("aluctl_%0d", i), {28'h0, aluctl}, {28'h0, alu_tab[i].ex});
    end
    idle();

    // mult -3 * 5: latency and busy length
    @(posedge clk);
    #1 issueMd(6'h18, 32'hFFFFFFFD, 32'd5);
    waitDone(cyc, ok);
    checkOutput("mult_done", {31'h0, ok}, 32'h1);
    checkOutput("mult_busy_cycles", cyc, 32'd33);
    checkOutput("mult_busy_in_done", {31'h0, busy}, 32'h0);
    done_expected++;
    @(posedge clk);
    #1 readHilo("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);

    runMd("divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    runMd("div_neg", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runMd("div_min", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    runMd("divu_zero", 6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    runMd("div_zero_s", 6'h1A, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);

    // flush during a divide: no done, HI/LO keep prior values
    runMd("divu_zero2", 6'h1B, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    issueMd(6'h1A, 32'd100, 32'd3);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy_before", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_busy_after", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    checkOutput("flush_no_done", done_seen, done_expected);
    @(posedge clk);
    #1 readHilo("flush", 32'd5, 32'hFFFFFFFF);

    // mthi / mtlo
    applyStimulus(2'd2, 6'h11, 32'h12345678, 32'h0, 1'b1);
    @(posedge clk);
    #1 applyStimulus(2'd2, 6'h13, 32'hCAFEBABE, 32'h0, 1'b1);
    @(posedge clk);
    #1 idle();
    readHilo("mt", 32'h12345678, 32'hCAFEBABE);
    checkOutput("mt_no_done", done_seen, done_expected);

    // mflo right behind a mult stalls until the done cycle
    issueMd(6'h18, 32'd7, 32'd6);
    sb_q.push_back('{"mflo_stall_lo", 32'd42});
    applyStimulus(2'd2, 6'h12, 32'h0, 32'h0, 1'b1);
    stall_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) break;
      stall_cycles++;
    end
    checkOutput("mflo_stall_cycles", stall_cycles, 32'd33);
    checkOutput("mflo_stall_done", {31'h0, done}, 32'h1);
    done_expected++;
    @(posedge clk);
    #1 idle();
    readHilo("mflo_stall", 32'h0, 32'd42);

    // back-to-back: a new op accepted in the done cycle
    issueMd(6'h19, 32'h00010000, 32'h00010000);
    waitDone(cyc, ok);
    checkOutput("b2b_first_done", {31'h0, ok}, 32'h1);
    done_expected++;
    funct = 6'h12;
    #1 checkOutput("b2b_first_lo", hilo_rdata, 32'h0);
    funct = 6'h10;
    #1 checkOutput("b2b_first_hi", hilo_rdata, 32'h1);
    applyStimulus(2'd2, 6'h1B, 32'd1000, 32'd7, 1'b1);
    #1 checkOutput("b2b_no_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1 idle();
    waitDone(cyc, ok);
    checkOutput("b2b_second_done", {31'h0, ok}, 32'h1);
    done_expected++;
    @(posedge clk);
    #1 readHilo("b2b", 32'd6, 32'd142);

    // asynchronous reset in the middle of a mult
    issueMd(6'h18, 32'h1234, 32'h5678);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_mid_done", {31'h0, done}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    readHilo("rst_mid", 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    checkOutput("queue_empty", sb_q.size(), 32'h0);
    checkOutput("done_count", done_seen, done_expected);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
